// File: rtl/ras_ctrl.sv
// Return-address-stack controller: circular stack of predicted return targets
// with push/pop/replace sequencing, overflow/underflow pulses and flush restore.
module ras_ctrl #(
  parameter  int DEPTH = 8,
  localparam int PTRW  = $clog2(DEPTH),
  localparam int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            fetch_vld_i,
  input  logic            brext_f1_i,
  input  logic [1:0]      rasctl_f1_i,
  input  logic [63:0]     rasdat_f1_i,
  input  logic            flush_vld_i,
  input  logic [PTRW-1:0] flush_tos_i,
  input  logic [CNTW-1:0] flush_cnt_i,
  output logic [63:0]     ras_pcdata_f0_o,
  output logic [PTRW-1:0] ras_tos_o,
  output logic [CNTW-1:0] ras_cnt_o,
  output logic            ras_empty_o,
  output logic            ras_ovf_o,
  output logic            ras_unf_o
);

  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_PUSH  = 2'b01,
    OP_POP   = 2'b10,
    OP_SWAP  = 2'b11
  } ras_op_e;

  logic [63:0]     mem [DEPTH];
  logic [PTRW-1:0] tos_q, tos_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            empty_q;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            wr_en;
  logic [PTRW-1:0] wr_idx;
  logic            op_en;
  logic [63:0]     push_val;
  ras_op_e         op;

  // A flush cancels any operation decoded in the same cycle.
  assign op_en    = fetch_vld_i & brext_f1_i & ~flush_vld_i;
  assign push_val = rasdat_f1_i + 64'h4;
  assign op       = ras_op_e'(rasctl_f1_i);

  // Next pointer, occupancy, entry write and pulse decode.
  always_comb begin
    tos_d  = tos_q;
    cnt_d  = cnt_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    wr_en  = 1'b0;
    wr_idx = tos_q;
    if (flush_vld_i) begin
      tos_d = flush_tos_i;
      cnt_d = (flush_cnt_i > FULL_CNT) ? FULL_CNT : flush_cnt_i;
    end else if (op_en) begin
      unique case (op)
        OP_PUSH: begin
          tos_d  = tos_q + PTRW'(1);
          wr_en  = 1'b1;
          wr_idx = tos_q + PTRW'(1);
          if (cnt_q == FULL_CNT) ovf_d = 1'b1;
          else                   cnt_d = cnt_q + CNTW'(1);
        end
        OP_POP: begin
          if (cnt_q == '0) begin
            unf_d = 1'b1;
          end else begin
            tos_d = tos_q - PTRW'(1);
            cnt_d = cnt_q - CNTW'(1);
          end
        end
        OP_SWAP: begin
          wr_en  = 1'b1;
          wr_idx = tos_q;
          if (cnt_q == '0) cnt_d = CNTW'(1);
        end
        default: ;
      endcase
    end
  end

  // Pointer, occupancy, empty flag and one-cycle event pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tos_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage; reset clears every entry so stale targets never leak out.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= push_val;
    end
  end

  assign ras_pcdata_f0_o = (cnt_q != '0) ? mem[tos_q] : 64'h0;
  assign ras_tos_o       = tos_q;
  assign ras_cnt_o       = cnt_q;
  assign ras_empty_o     = empty_q;
  assign ras_ovf_o       = ovf_q;
  assign ras_unf_o       = unf_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// Testbench for ras_ctrl: stack-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ras_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_vld;
  logic        brext;
  logic [1:0]  rasctl;
  logic [63:0] rasdat;
  logic        flush_vld;
  logic [2:0]  flush_tos;
  logic [3:0]  flush_cnt;
  logic [63:0] pcdata;
  logic [2:0]  tos;
  logic [3:0]  cnt;
  logic        empty;
  logic        ovf;
  logic        unf;

  int total_checks = 0;
  int passed_checks = 0;

  ras_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .fetch_vld_i     (fetch_vld),
    .brext_f1_i      (brext),
    .rasctl_f1_i     (rasctl),
    .rasdat_f1_i     (rasdat),
    .flush_vld_i     (flush_vld),
    .flush_tos_i     (flush_tos),
    .flush_cnt_i     (flush_cnt),
    .ras_pcdata_f0_o (pcdata),
    .ras_tos_o       (tos),
    .ras_cnt_o       (cnt),
    .ras_empty_o     (empty),
    .ras_ovf_o       (ovf),
    .ras_unf_o       (unf)
  );

  always #5 clk = ~clk;

  // Reference model: a physical ring of DEPTH return targets addressed by
  // integer pointer arithmetic modulo DEPTH.
  logic [63:0] m_mem [DEPTH];
  int          m_tos = 0;
  int          m_cnt = 0;
  bit          m_ovf = 0;
  bit          m_unf = 0;

  // Model update on each clock edge, or immediately on reset assertion.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 64'h0;
      m_tos = 0;
      m_cnt = 0;
      m_ovf = 0;
      m_unf = 0;
    end else begin
      m_ovf = 0;
      m_unf = 0;
      if (flush_vld) begin
        m_tos = int'(flush_tos);
        m_cnt = (int'(flush_cnt) > DEPTH) ? DEPTH : int'(flush_cnt);
      end else if (fetch_vld && brext) begin
        case (rasctl)
          2'b01: begin
            m_tos = (m_tos + 1) % DEPTH;
            m_mem[m_tos] = rasdat + 64'd4;
            if (m_cnt == DEPTH) m_ovf = 1;
            else m_cnt = m_cnt + 1;
          end
          2'b10: begin
            if (m_cnt == 0) m_unf = 1;
            else begin
              m_tos = (m_tos + DEPTH - 1) % DEPTH;
              m_cnt = m_cnt - 1;
            end
          end
          2'b11: begin
            m_mem[m_tos] = rasdat + 64'd4;
            if (m_cnt == 0) m_cnt = 1;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    total_checks++;
    if (actual === expected) passed_checks++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    check_output("model_pcdata", pcdata, (m_cnt > 0) ? m_mem[m_tos] : 64'h0);
    check_output("model_tos", 64'(tos), 64'(m_tos));
    check_output("model_cnt", 64'(cnt), 64'(m_cnt));
    check_output("model_empty", 64'(empty), 64'(m_cnt == 0));
    check_output("model_ovf", 64'(ovf), 64'(m_ovf));
    check_output("model_unf", 64'(unf), 64'(m_unf));
  end

  // Drive one cycle of inputs, then return 2ns after the consuming edge.
  task automatic apply_stimulus(input logic fv, input logic br, input logic [1:0] ctl,
                                input logic [63:0] dat, input logic fl = 1'b0,
                                input logic [2:0] ftos = 3'd0, input logic [3:0] fcnt = 4'd0);
    fetch_vld = fv;
    brext     = br;
    rasctl    = ctl;
    rasdat    = dat;
    flush_vld = fl;
    flush_tos = ftos;
    flush_cnt = fcnt;
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [63:0] dat);
    apply_stimulus(1'b1, 1'b1, 2'b01, dat);
  endtask

  task automatic pop();
    apply_stimulus(1'b1, 1'b1, 2'b10, 64'h0);
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 2'b00, 64'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_output("async_reset_tos", 64'(tos), 64'h0);
    check_output("async_reset_cnt", 64'(cnt), 64'h0);
    check_output("async_reset_pcdata", pcdata, 64'h0);
    check_output("async_reset_empty", 64'(empty), 64'h1);
    idle();
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_vld = 1'b0; brext = 1'b0; rasctl = 2'b00; rasdat = 64'h0;
    flush_vld = 1'b0; flush_tos = 3'd0; flush_cnt = 4'd0;
    @(posedge clk);
    #2;
    idle();
    check_output("reset_cnt", 64'(cnt), 64'h0);
    check_output("reset_ovf", 64'(ovf), 64'h0);
    rst_n = 1'b1;
    idle();

    // Single push
    push(64'h1000);
    check_output("push1_pcdata", pcdata, 64'h1004);
    check_output("push1_tos", 64'(tos), 64'h1);
    check_output("push1_cnt", 64'(cnt), 64'h1);
    check_output("push1_empty", 64'(empty), 64'h0);

    // LIFO order
    push(64'h2000);
    push(64'h3000);
    check_output("lifo_top3", pcdata, 64'h3004);
    pop();
    check_output("lifo_pop1", pcdata, 64'h2004);
    pop();
    check_output("lifo_pop2", pcdata, 64'h1004);
    pop();
    check_output("lifo_pop3", pcdata, 64'h0);
    check_output("lifo_empty", 64'(empty), 64'h1);

    // Underflow pulse
    pop();
    check_output("unf_pulse", 64'(unf), 64'h1);
    check_output("unf_cnt", 64'(cnt), 64'h0);
    idle();
    check_output("unf_cleared", 64'(unf), 64'h0);

    // Wraparound and overflow: tos starts at 0 here
    for (int k = 1; k <= 8; k++) push(64'(k) * 64'h100);
    check_output("full_no_ovf", 64'(ovf), 64'h0);
    push(64'h900);
    check_output("ovf_pulse", 64'(ovf), 64'h1);
    check_output("ovf_cnt", 64'(cnt), 64'h8);
    check_output("ovf_tos", 64'(tos), 64'h1);
    check_output("ovf_top", pcdata, 64'h904);
    for (int k = 1; k <= 7; k++) begin
      pop();
      check_output("drain_top", pcdata, 64'(9 - k) * 64'h100 + 64'h4);
    end
    pop();
    check_output("drain_empty", 64'(empty), 64'h1);
    pop();
    check_output("drain_unf", 64'(unf), 64'h1);

    // Ignored requests: brext low, fetch not valid
    apply_stimulus(1'b1, 1'b0, 2'b01, 64'hABC0);
    apply_stimulus(1'b0, 1'b1, 2'b01, 64'hABC0);
    check_output("ignored_cnt", 64'(cnt), 64'h0);

    // Pop-then-push on empty stack
    apply_stimulus(1'b1, 1'b1, 2'b11, 64'h7770);
    check_output("swap_empty_cnt", 64'(cnt), 64'h1);
    check_output("swap_empty_top", pcdata, 64'h7774);

    // Reset mid-sequence
    push(64'h4440);
    do_reset();
    check_output("post_reset_cnt", 64'(cnt), 64'h0);

    // Pop-then-push replaces the top entry
    push(64'h1000);
    push(64'h2000);
    apply_stimulus(1'b1, 1'b1, 2'b11, 64'h5000);
    check_output("swap_top", pcdata, 64'h5004);
    check_output("swap_cnt", 64'(cnt), 64'h2);
    pop();
    check_output("swap_pop_top", pcdata, 64'h1004);

    // Flush priority over a concurrent push
    do_reset();
    push(64'h1000);
    push(64'h2000);
    apply_stimulus(1'b1, 1'b1, 2'b01, 64'h7000, 1'b1, 3'd1, 4'd1);
    check_output("flush_tos", 64'(tos), 64'h1);
    check_output("flush_cnt", 64'(cnt), 64'h1);
    check_output("flush_top", pcdata, 64'h1004);

    // Flush count clamp, then overflow and replace at full
    apply_stimulus(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 3'd2, 4'd15);
    check_output("flush_clamp_cnt", 64'(cnt), 64'h8);
    check_output("flush_clamp_top", pcdata, 64'h2004);
    apply_stimulus(1'b1, 1'b1, 2'b11, 64'h6000);
    check_output("swap_full_ovf", 64'(ovf), 64'h0);
    push(64'hA000);
    check_output("full_push_ovf", 64'(ovf), 64'h1);
    check_output("full_push_tos", 64'(tos), 64'h3);
    idle();
    idle();

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Return-address-stack controller for the fetch unit.
- Consumes the per-bundle RAS control, RAS data and branch-exist indication from the fetch-stage branch decoder, and sequences push, pop and replace operations on a circular stack.
- Drives the predicted return target back to the decoder for the next bundle.
- Restores the stack pointer and occupancy on pipeline flush from a checkpoint supplied by the recovery logic.

Parameters:
- DEPTH, 8, number of stack entries; power of 2, minimum 2.
- PTRW, log2(DEPTH) = 3, top-of-stack pointer width; derived, not overridable.
- CNTW, log2(DEPTH)+1 = 4, occupancy counter width; derived, not overridable.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- fetch_vld_i  in  1  current F1 bundle is valid and advancing.
- brext_f1_i  in  1  bundle contains a branch.
- rasctl_f1_i  in  2  00 none, 01 push (call), 10 pop (return), 11 pop-then-push (coroutine).
- rasdat_f1_i  in  64  PC of the branch instruction.
- flush_vld_i  in  1  pipeline flush; restore checkpoint.
- flush_tos_i  in  PTRW  checkpointed top-of-stack pointer.
- flush_cnt_i  in  CNTW  checkpointed occupancy.
- ras_pcdata_f0_o  out  64  predicted return address (top entry).
- ras_tos_o  out  PTRW  current top-of-stack pointer, for checkpointing.
- ras_cnt_o  out  CNTW  current occupancy, 0..DEPTH.
- ras_empty_o  out  1  ras_cnt_o == 0.
- ras_ovf_o  out  1  one-cycle pulse: push overwrote the oldest entry.
- ras_unf_o  out  1  one-cycle pulse: pop attempted on an empty stack.

Behaviour:
- Reset (async, rst_n_i=0):
  - tos=0, cnt=0, all entries 64'h0, ras_ovf_o=0, ras_unf_o=0.
  - Outputs take their reset values immediately, without waiting for a clock edge.
- An operation occurs when op_en = fetch_vld_i & brext_f1_i & !flush_vld_i.
- Push value is rasdat_f1_i + 64'h4, modulo 2^64.
- Push (01):
  - Write mem[tos+1] and advance tos by 1; the pointer wraps modulo DEPTH.
  - If cnt < DEPTH: increment cnt.
  - If cnt == DEPTH: cnt stays at DEPTH, the oldest entry is overwritten, and ras_ovf_o pulses for 1 cycle.
- Pop (10):
  - If cnt > 0: decrement tos modulo DEPTH and decrement cnt. Memory is not modified.
  - If cnt == 0: tos and cnt are unchanged and ras_unf_o pulses for 1 cycle.
- Pop-then-push (11):
  - Write mem[tos] with the push value; tos and cnt are unchanged.
  - If cnt == 0, cnt becomes 1. No ovf or unf pulse in either case.
- None (00), or op_en=0: no state change.
- Flush:
  - Has priority over any same-cycle operation.
  - tos <= flush_tos_i; cnt <= min(flush_cnt_i, DEPTH). Memory is untouched.
  - No ovf or unf pulse in a flush cycle.
- ras_pcdata_f0_o:
  - Combinational read of mem[tos] when cnt > 0; 64'h0 when cnt == 0.
  - Reflects state after the last clock edge, so a push at edge N is visible starting the cycle after edge N. There is no same-cycle bypass.
- ras_tos_o, ras_cnt_o and ras_empty_o are direct register outputs.
- ras_ovf_o and ras_unf_o are registered pulses, asserted the cycle after the causing edge and cleared the following cycle unless re-triggered.
- rasctl_f1_i is ignored when brext_f1_i=0, regardless of its value.
- Reset asserted mid-sequence discards all entries; the first operation after release sees an empty stack.

Test Plan:
- Reset, then push with rasdat=0x1000 -> next cycle ras_pcdata_f0_o=0x1004, ras_tos_o=1, ras_cnt_o=1, ras_empty_o=0.
- Push 0x1000, 0x2000, 0x3000, then pop ×3 -> ras_pcdata_f0_o steps 0x3004 → 0x2004 → 0x1004 → 0x0; ras_empty_o=1 after the third pop.
- Pop on an empty stack -> ras_unf_o=1 for exactly 1 cycle; tos and cnt stay 0; ras_pcdata_f0_o=0.
- 9 pushes with rasdat=0x100*k (k=1..9), DEPTH=8:
  - 9th push -> ras_ovf_o pulses, cnt=8, tos=1, top=0x904.
  - 8 pops then return 0x804 … 0x204; the 9th pop -> ras_unf_o.
- Push 0x1000, push 0x2000, then pop-then-push with rasdat=0x5000 -> top=0x5004, cnt=2; a following pop exposes 0x1004.
- Two pushes (tos=2, cnt=2) with flush_vld_i=1, flush_tos_i=1, flush_cnt_i=1 and a concurrent push request -> push ignored; tos=1, cnt=1, top=0x1004.
- flush_cnt_i=15 -> cnt clamps to 8.
